// File: rtl/cmp_pkg.sv
// Shared compare codes and FSM state encoding for the serial word comparator.
package cmp_pkg;

  typedef logic [1:0] cmp_t;

  localparam cmp_t CMP_EQ = 2'b00;
  localparam cmp_t CMP_LT = 2'b01;
  localparam cmp_t CMP_GT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_bit_cell.sv
// One bit pair of an MSB-first magnitude compare; an earlier difference always wins.
module cmp_bit_cell
  import cmp_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  cmp_t i_prev,
  output cmp_t o_next
);

  always_comb begin
    o_next = i_prev;
    if (i_prev == CMP_EQ) begin
      if (i_a && !i_b)      o_next = CMP_GT;
      else if (!i_a && i_b) o_next = CMP_LT;
    end
  end

endmodule

// File: rtl/serial_word_comparator.sv
// Bit-serial unsigned magnitude comparator with valid/ready on both sides.
module serial_word_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 result,
  output logic [$clog2(WIDTH+1)-1:0] bits_used
);

  localparam int CW = $clog2(WIDTH+1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  cmp_t             r_acc;
  logic [CW-1:0]    r_cnt;
  cmp_t             w_cell;
  logic             w_last;

  cmp_bit_cell u_cell (
    .i_a    (r_a_sr[WIDTH-1]),
    .i_b    (r_b_sr[WIDTH-1]),
    .i_prev (r_acc),
    .o_next (w_cell)
  );

  // Last scan cycle: either all bits consumed or the answer is already settled.
  assign w_last = ((int'(r_cnt) + 1) == WIDTH) ||
                  (EARLY_EXIT && (w_cell != CMP_EQ));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_acc;
  assign bits_used = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= CMP_EQ;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_acc   <= CMP_EQ;
            r_cnt   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_acc  <= w_cell;
          r_cnt  <= r_cnt + CW'(1);
          r_a_sr <= r_a_sr << 1;
          r_b_sr <= r_b_sr << 1;
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Scoreboard bench: one early-exit and one fixed-latency comparator side by side.
module tb_serial_word_comparator;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv0, ir0, ov0, or0;
  logic [7:0] a0, b0;
  logic [1:0] res0;
  logic [3:0] bu0;
  logic       iv1, ir1, ov1, or1;
  logic [7:0] a1, b1;
  logic [1:0] res1;
  logic [3:0] bu1;

  int errors = 0;
  int checks = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];

  serial_word_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .result(res0), .bits_used(bu0));

  serial_word_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .result(res1), .bits_used(bu1));

  // Expected {result, bits_used} from a plain MSB-first walk over the operands.
  function automatic logic [5:0] model(input logic [7:0] x, input logic [7:0] y, input bit ee);
    logic [1:0] r = CMP_EQ;
    logic [3:0] n = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (r == CMP_EQ && x[i] != y[i]) begin
        r = x[i] ? CMP_GT : CMP_LT;
        if (ee) n = 4'(8 - i);
      end
    end
    return {r, n};
  endfunction

  function automatic logic get_ov(input int s);  return s ? ov1 : ov0;  endfunction
  function automatic logic get_ir(input int s);  return s ? ir1 : ir0;  endfunction
  function automatic logic [5:0] get_out(input int s);
    return s ? {res1, bu1} : {res0, bu0};
  endfunction

  // Called at the negedge right after the accept edge; waits for out_valid and scores it.
  task automatic wait_result(input int s, input string nm);
    int c = 0;
    logic [5:0] e;
    while (get_ov(s) !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (get_ov(s) !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: out_valid never rose within %0d cycles", nm, c);
      return;
    end
    checks++;
    if ((s ? q1.size() : q0.size()) == 0) begin
      errors++;
      $display("FAIL %s scoreboard: output with no expected entry", nm);
      return;
    end
    e = s ? q1.pop_front() : q0.pop_front();
    checks++;
    if (get_out(s) !== e) begin
      errors++;
      $display("FAIL %s data: got result=%0d bits_used=%0d, want result=%0d bits_used=%0d",
               nm, get_out(s)[5:4], get_out(s)[3:0], e[5:4], e[3:0]);
    end
    checks++;
    if (c != int'(e[3:0])) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", nm, c, e[3:0]);
    end
  endtask

  // Drive one operand pair into DUT s and check its result; out_ready assumed high.
  task automatic run_op(input int s, input logic [7:0] x, input logic [7:0] y, input string nm);
    @(negedge clk);
    checks++;
    if (get_ir(s) !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", nm, get_ir(s));
    end
    if (s == 0) begin a0 = x; b0 = y; iv0 = 1'b1; q0.push_back(model(x, y, 1'b1)); end
    else        begin a1 = x; b1 = y; iv1 = 1'b1; q1.push_back(model(x, y, 1'b0)); end
    @(negedge clk);
    if (s == 0) begin iv0 = 1'b0; a0 = ~x; b0 = ~y; end
    else        begin iv1 = 1'b0; a1 = ~x; b1 = ~y; end
    wait_result(s, nm);
    @(negedge clk);
    checks++;
    if (get_ov(s) !== 1'b0 || get_ir(s) !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b, want 0/1", nm, get_ov(s), get_ir(s));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov0, ir0, res0, bu0} !== {1'b0, 1'b1, CMP_EQ, 4'd0}) begin
      errors++;
      $display("FAIL reset dut0: ov=%b ir=%b res=%0d bu=%0d, want 0 1 0 0", ov0, ir0, res0, bu0);
    end
    checks++;
    if ({ov1, ir1, res1, bu1} !== {1'b0, 1'b1, CMP_EQ, 4'd0}) begin
      errors++;
      $display("FAIL reset dut1: ov=%b ir=%b res=%0d bu=%0d, want 0 1 0 0", ov1, ir1, res1, bu1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_early_exit();
    run_op(0, 8'h5A, 8'h5A, "eq_5a");
    run_op(0, 8'h80, 8'h7F, "gt_msb");
    run_op(0, 8'h12, 8'h13, "lt_lsb");
    run_op(0, 8'h00, 8'h40, "lt_bit6");
    run_op(0, 8'hFF, 8'hFF, "eq_ff");
  endtask

  task automatic test_fixed_latency();
    run_op(1, 8'h80, 8'h7F, "fixed_gt");
    run_op(1, 8'h00, 8'h01, "fixed_lt");
    run_op(1, 8'h33, 8'h33, "fixed_eq");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = (i % 3 == 0) ? x : 8'($urandom);
      run_op(0, x, y, "rand_ee");
      run_op(1, x, y, "rand_fixed");
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] held;
    or0 = 1'b0;
    @(negedge clk);
    a0 = 8'h0F; b0 = 8'h1F; iv0 = 1'b1;
    q0.push_back(model(8'h0F, 8'h1F, 1'b1));
    @(negedge clk);
    iv0 = 1'b0;
    wait_result(0, "bp_first");
    held = {res0, bu0};
    a0 = 8'hFF; b0 = 8'h00; iv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b1 || ir0 !== 1'b0 || {res0, bu0} !== held) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: ov=%b ir=%b out=%h, want 1 0 %h", i, ov0, ir0, {res0, bu0}, held);
      end
    end
    or0 = 1'b1;
    q0.push_back(model(8'hFF, 8'h00, 1'b1));
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b, want 0 1", ov0, ir0);
    end
    @(negedge clk);
    iv0 = 1'b0;
    wait_result(0, "bp_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    a0 = 8'h01; b0 = 8'h02; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov0, ir0, res0, bu0} !== {1'b0, 1'b1, CMP_EQ, 4'd0}) begin
      errors++;
      $display("FAIL rst_mid: ov=%b ir=%b res=%0d bu=%0d, want 0 1 0 0", ov0, ir0, res0, bu0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale cycle %0d: out_valid=%b want 0", i, ov0);
      end
    end
    run_op(0, 8'h01, 8'h02, "post_rst");
  endtask

  initial begin
    rst_n = 1'b0;
    iv0 = 1'b0; or0 = 1'b1; a0 = '0; b0 = '0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
    test_reset();
    test_early_exit();
    test_fixed_latency();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
